cpu_mem_responder: RTL

- Memory-side responder for the CPU's 8-bit load/store/fetch bus; the other end of the CPU's memory-initiator interface.
- Accepts one request at a time over a valid/ready request channel.
- Models a configurable number of wait states, performs the read or write on an internal register-array memory, and returns the result over a valid/ready response channel.
- Addresses at or above DEPTH are flagged as errors.

---
 rtl/cpu_mem_responder_if.sv | 26 ++
 rtl/cpu_mem_responder.sv | 119 +++++++++++
 2 files changed

// File: rtl/cpu_mem_responder_if.sv
// Request/response channel between the CPU memory initiator and the memory responder.
// The request and response channels are independent valid/ready handshakes.
interface cpu_mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU load/store/fetch bus: one request at a time,
// programmable wait states, register-array memory, out-of-range addresses flagged.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | req_ready high, waiting for a request
// ST_WAIT | request latched, counting down wait states
// ST_RESP | rsp_valid high, response held until rsp_ready
module cpu_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 reset,
  cpu_mem_responder_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              do_access;
  logic              acc_write;
  logic              acc_in_range;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [IDX_W-1:0]  acc_idx;

  assign bus.req_ready = (state == ST_IDLE) && reset;
  assign accept        = bus.req_valid && bus.req_ready;

  // With zero wait states the access happens on the acceptance edge, straight from the bus.
  always_comb begin
    acc_write = lat_write;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    do_access = 1'b0;
    if (state == ST_IDLE) begin
      acc_write = bus.req_write;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      do_access = accept && (WAIT_CYCLES == 0);
    end else if (state == ST_WAIT) begin
      do_access = (cnt == 4'd0);
    end
    acc_in_range = {1'b0, acc_addr} < DEPTH_LIM;
    acc_idx      = acc_addr[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (do_access && acc_write && acc_in_range) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      cnt           <= 4'd0;
      lat_write     <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_write <= bus.req_write;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state         <= ST_IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (do_access) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= !acc_in_range;
        bus.rsp_rdata <= (acc_in_range && !acc_write) ? mem[acc_idx] : '0;
      end
    end
  end

endmodule
